// File: rtl/shift_ser_pkg.sv
// shift_ser_pkg: shared defaults, holding-register state type and idle word
// for the requester-to-serializer arbiter.
package shift_ser_pkg;
    localparam int FROM_DEF = 16;
    localparam int TO_DEF   = 4;
    localparam int NREQ_DEF = 4;
    localparam logic [FROM_DEF-1:0] IDLE_WORD = '0;
    typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of one valid requester starting at i_ptr,
// returning a one-hot grant and its index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);
    always_comb begin
        int j;
        j = 0;
        o_gnt = '0;
        o_idx = '0;
        // walk offsets downward so the nearest requester to i_ptr wins last
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(i_ptr) + k) % N;
            if (i_en && i_req[j]) begin
                o_gnt    = '0;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/serializer_arbiter.sv
// serializer_arbiter: arbitrates NREQ requesters into a one-word holding
// register that feeds a shift serializer on each ser_ready_i strobe.
module serializer_arbiter import shift_ser_pkg::*; #(
    parameter int FROM = FROM_DEF,
    parameter int TO   = TO_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter logic [FROM-1:0] IDLE_WORD = FROM'(shift_ser_pkg::IDLE_WORD),
    parameter int IW   = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en_i,
    input  logic [NREQ-1:0]           req_valid_i,
    input  logic [NREQ-1:0][FROM-1:0] req_data_i,
    output logic [NREQ-1:0]           req_ready_o,
    input  logic                      ser_ready_i,
    output logic [FROM-1:0]           ser_data_o,
    output logic                      ser_valid_o,
    output logic [IW-1:0]             ser_id_o,
    output logic [15:0]               words_o
);
    if (FROM % TO != 0) begin : g_width_check
        $error("FROM must be a multiple of TO");
    end

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [FROM-1:0] r_hold;
    logic [IW-1:0]   r_id;
    logic [15:0]     r_words;
    logic            w_slot;
    logic            w_xfer;
    logic            w_load;
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;

    assign w_slot = en_i && (r_state == EMPTY || ser_ready_i);
    assign w_load = ser_ready_i && r_state == FULL;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
        .i_req (req_valid_i),
        .i_ptr (r_ptr),
        .i_en  (w_slot),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    // grants are masked during reset so nothing is accepted into a cleared register
    assign req_ready_o = reset ? '0 : w_gnt;
    assign w_xfer      = |req_ready_o;
    assign ser_valid_o = r_state == FULL;
    assign ser_data_o  = ser_valid_o ? r_hold : IDLE_WORD;
    assign ser_id_o    = ser_valid_o ? r_id : '0;
    assign words_o     = r_words;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_id    <= '0;
            r_words <= '0;
        end else begin
            if (w_load && r_words != 16'hFFFF)
                r_words <= r_words + 16'd1;
            if (w_xfer) begin
                r_state <= FULL;
                r_hold  <= req_data_i[w_idx];
                r_id    <= w_idx;
                r_ptr   <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            end else if (w_load) begin
                r_state <= EMPTY;
            end
        end
    end
endmodule

// File: tb/tb_serializer_arbiter.sv
// tb_serializer_arbiter: scoreboard bench; expected {id,word} pairs are queued
// at grant time and checked whenever the serializer loads.
module tb_serializer_arbiter;
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en_i = 1'b0;
    logic [3:0]       req_valid_i = '0;
    logic [3:0][15:0] req_data_i = '0;
    logic [3:0]       req_ready_o;
    logic             ser_ready_i = 1'b0;
    logic [15:0]      ser_data_o;
    logic             ser_valid_o;
    logic [1:0]       ser_id_o;
    logic [15:0]      words_o;

    int n_checks = 0;
    int n_fail = 0;
    logic [17:0] sb[$];

    serializer_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .en_i        (en_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .ser_ready_i (ser_ready_i),
        .ser_data_o  (ser_data_o),
        .ser_valid_o (ser_valid_o),
        .ser_id_o    (ser_id_o),
        .words_o     (words_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && ser_ready_i && ser_valid_o) begin
            logic [17:0] exp;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL load_unexpected: got id=%0d data=%h, required no load", ser_id_o, ser_data_o);
            end else begin
                exp = sb.pop_front();
                if ({ser_id_o, ser_data_o} !== exp) begin
                    n_fail++;
                    $display("FAIL load_word: got id=%0d data=%h, required id=%0d data=%h",
                             ser_id_o, ser_data_o, exp[17:16], exp[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [15:0] d);
        sb.push_back({2'(id), d});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en_i = 1'b1;
        req_valid_i = 4'hF;
        repeat (2) tick();
        n_checks++;
        if (req_ready_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, required 0000", req_ready_o);
        end
        n_checks++;
        if ({ser_valid_o, ser_data_o, ser_id_o, words_o} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b data=%h id=%0d words=%0d, required all zero",
                     ser_valid_o, ser_data_o, ser_id_o, words_o);
        end
        req_valid_i = '0;
        en_i = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_idle();
        en_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            ser_ready_i = (c % 4 == 3);
            tick();
        end
        ser_ready_i = 1'b0;
        n_checks++;
        if ({ser_valid_o, ser_data_o, words_o, req_ready_o} !== 37'd0) begin
            n_fail++;
            $display("FAIL idle: got valid=%b data=%h words=%0d ready=%b, required zeros",
                     ser_valid_o, ser_data_o, words_o, req_ready_o);
        end
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 4; i++) req_data_i[i] = 16'hA000 + 16'(i);
        req_valid_i = 4'hF;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL rr_first_grant: got %b, required 0001", req_ready_o);
        end
        push(0, 16'hA000);
        tick();
        n_checks++;
        if (req_ready_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL rr_full_no_grant: got %b, required 0000", req_ready_o);
        end
        for (int s = 0; s < 5; s++) begin
            repeat (3) tick();
            ser_ready_i = 1'b1;
            #1;
            n_checks++;
            if (req_ready_o !== 4'(1 << ((s + 1) % 4))) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: got %b, required %b", s, req_ready_o, 4'(1 << ((s + 1) % 4)));
            end
            push((s + 1) % 4, 16'hA000 + 16'((s + 1) % 4));
            tick();
            ser_ready_i = 1'b0;
        end
        n_checks++;
        if (words_o !== 16'd5) begin
            n_fail++;
            $display("FAIL rr_words: got %0d, required 5", words_o);
        end
        req_valid_i = '0;
        ser_ready_i = 1'b1;
        tick();
        ser_ready_i = 1'b0;
        n_checks++;
        if (ser_valid_o !== 1'b0 || words_o !== 16'd6) begin
            n_fail++;
            $display("FAIL rr_drain: got valid=%b words=%0d, required valid=0 words=6", ser_valid_o, words_o);
        end
    endtask

    task automatic test_back_to_back();
        req_data_i[2] = 16'h1234;
        req_valid_i = 4'b0100;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL b2b_grant1: got %b, required 0100", req_ready_o);
        end
        push(2, 16'h1234);
        tick();
        req_data_i[2] = 16'h5678;
        tick();
        ser_ready_i = 1'b1;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL b2b_grant2: got %b, required 0100", req_ready_o);
        end
        push(2, 16'h5678);
        tick();
        ser_ready_i = 1'b0;
        req_valid_i = '0;
        n_checks++;
        if (ser_valid_o !== 1'b1 || ser_data_o !== 16'h5678) begin
            n_fail++;
            $display("FAIL b2b_no_bubble: got valid=%b data=%h, required valid=1 data=5678", ser_valid_o, ser_data_o);
        end
        ser_ready_i = 1'b1;
        tick();
        ser_ready_i = 1'b0;
        n_checks++;
        if (words_o !== 16'd8 || ser_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_words: got words=%0d valid=%b, required words=8 valid=0", words_o, ser_valid_o);
        end
    endtask

    task automatic test_enable_low();
        req_data_i[1] = 16'hBEEF;
        req_valid_i = 4'b0010;
        push(1, 16'hBEEF);
        tick();
        en_i = 1'b0;
        req_valid_i = 4'hF;
        tick();
        ser_ready_i = 1'b1;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL en_low_strobe_grant: got %b, required 0000", req_ready_o);
        end
        tick();
        ser_ready_i = 1'b0;
        n_checks++;
        if (ser_valid_o !== 1'b0 || ser_data_o !== 16'h0000) begin
            n_fail++;
            $display("FAIL en_low_empty: got valid=%b data=%h, required valid=0 data=0000", ser_valid_o, ser_data_o);
        end
        repeat (3) tick();
        n_checks++;
        if (req_ready_o !== 4'b0000 || ser_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL en_low_no_grant: got ready=%b valid=%b, required 0000/0", req_ready_o, ser_valid_o);
        end
        req_valid_i = '0;
        en_i = 1'b1;
    endtask

    task automatic test_async_reset();
        req_data_i[0] = 16'h7777;
        req_valid_i = 4'b0001;
        tick();
        req_valid_i = '0;
        tick();
        n_checks++;
        if (ser_valid_o !== 1'b1 || ser_data_o !== 16'h7777) begin
            n_fail++;
            $display("FAIL areset_pre_full: got valid=%b data=%h, required valid=1 data=7777", ser_valid_o, ser_data_o);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (ser_valid_o !== 1'b0 || ser_data_o !== 16'h0000 || words_o !== 16'd0) begin
            n_fail++;
            $display("FAIL areset_immediate: got valid=%b data=%h words=%0d, required 0/0000/0",
                     ser_valid_o, ser_data_o, words_o);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) req_data_i[i] = 16'hA000 + 16'(i);
        req_valid_i = 4'hF;
        ser_ready_i = 1'b1;
        for (int k = 0; k < 65535; k++) begin
            push(k % 4, 16'hA000 + 16'(k % 4));
            tick();
        end
        n_checks++;
        if (words_o !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL sat_pre: got %h, required FFFE", words_o);
        end
        for (int k = 65535; k < 65538; k++) begin
            push(k % 4, 16'hA000 + 16'(k % 4));
            tick();
        end
        n_checks++;
        if (words_o !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold: got %h, required FFFF", words_o);
        end
        req_valid_i = '0;
        tick();
        ser_ready_i = 1'b0;
        n_checks++;
        if (words_o !== 16'hFFFF || ser_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_drain: got words=%h valid=%b, required FFFF/0", words_o, ser_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_round_robin();
        test_back_to_back();
        test_enable_low();
        test_async_reset();
        test_saturation();
        tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d pending words, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
